// File: rtl/xaddrgen_sched_pkg.sv
// Shared types and packing helpers for the address-generator run scheduler.
// Field offsets follow the LSB-first configuration bus layout.
package xaddrgen_sched_pkg;

    localparam int DEF_MEM_ADDR_W = 10;
    localparam int DEF_PERIOD_W   = 10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_GUARD0 = 3'd3,
        S_GUARD1 = 3'd4,
        S_WAIT   = 3'd5
    } sched_state_e;

    function automatic int cfg_width(input int aw, input int pw);
        return 7 * aw + 8 * pw;
    endfunction

    function automatic int off_duty(input int aw);
        return aw;
    endfunction

    function automatic int off_delay(input int aw, input int pw);
        return aw + pw;
    endfunction

    // k selects the loop pair: 0 -> loops 1-2, 1 -> 3-4, 2 -> 5-6
    function automatic int off_iter(input int aw, input int pw, input int k);
        return aw + 2 * pw + k * (2 * aw + 2 * pw);
    endfunction

    function automatic int off_period(input int aw, input int pw, input int k);
        return off_iter(aw, pw, k) + pw;
    endfunction

    function automatic int off_shift(input int aw, input int pw, input int k);
        return off_iter(aw, pw, k) + 2 * pw;
    endfunction

    function automatic int off_incr(input int aw, input int pw, input int k);
        return off_iter(aw, pw, k) + 2 * pw + aw;
    endfunction

endpackage

// File: rtl/xcfg_fifo.sv
// Synchronous configuration FIFO with registered full/empty flags.
// A pop in the same cycle never frees space for a push while full.
module xcfg_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_push  = push & ~full_q & ~clear;
        do_pop   = pop & ~empty_q & ~clear;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
        full_d  = (cnt_d == CW'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/xaddrgen_sched.sv
// Run scheduler: queues generator configurations and launches them back to back.
// Guard states hide the previous run's done level from the new run.
module xaddrgen_sched
    import xaddrgen_sched_pkg::*;
#(
    parameter  int MEM_ADDR_W = DEF_MEM_ADDR_W,
    parameter  int PERIOD_W   = DEF_PERIOD_W,
    parameter  int DEPTH      = 2,
    localparam int CFG_W      = cfg_width(MEM_ADDR_W, PERIOD_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CFG_W-1:0] cfg_in,
    output logic [CFG_W-1:0] ag_cfg,
    output logic             ag_run,
    input  logic             ag_done,
    output logic             busy,
    output logic             drained,
    output logic [15:0]      run_cnt
);

    sched_state_e     state_q, state_d;
    logic [CFG_W-1:0] ag_cfg_q, ag_cfg_d;
    logic             ag_run_q, ag_run_d;
    logic             busy_q, busy_d;
    logic             drained_q, drained_d;
    logic [15:0]      run_cnt_q, run_cnt_d;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CFG_W-1:0] fifo_head;

    xcfg_fifo #(
        .DEPTH (DEPTH),
        .W     (CFG_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (cfg_valid),
        .pop   (fifo_pop),
        .din   (cfg_in),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        ag_cfg_d  = ag_cfg_q;
        ag_run_d  = 1'b0;
        drained_d = 1'b0;
        run_cnt_d = run_cnt_q;
        fifo_pop  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (en && !fifo_empty) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // a flush between IDLE and LOAD leaves nothing to launch
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    ag_cfg_d = fifo_head;
                    ag_run_d = 1'b1;
                    state_d  = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN:    state_d = S_GUARD0;
            S_GUARD0: state_d = S_GUARD1;
            S_GUARD1: state_d = S_WAIT;
            S_WAIT: begin
                if (ag_done) begin
                    run_cnt_d = run_cnt_q + 16'd1;
                    drained_d = fifo_empty;
                    state_d   = (en && !fifo_empty) ? S_LOAD : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ag_cfg_q  <= '0;
            ag_run_q  <= 1'b0;
            busy_q    <= 1'b0;
            drained_q <= 1'b0;
            run_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ag_cfg_q  <= ag_cfg_d;
            ag_run_q  <= ag_run_d;
            busy_q    <= busy_d;
            drained_q <= drained_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    assign cfg_ready = ~fifo_full;
    assign ag_cfg    = ag_cfg_q;
    assign ag_run    = ag_run_q;
    assign busy      = busy_q;
    assign drained   = drained_q;
    assign run_cnt   = run_cnt_q;

endmodule
